// File: rtl/agc_gain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : agc_gain_ctrl                                                  |
// | Brief   : Closed-loop AGC sequencer stepping a gain code toward ref_pow. |
// |           Optional AGC_HYST_EN adds the tol port and a lock band.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module agc_gain_ctrl #(
   parameter int POW_WIDTH  = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int GAIN_INIT  = 128,
   parameter int GAIN_MIN   = 1,
   parameter int GAIN_MAX   = 255,
   parameter int SETTLE_LEN = 16,
   parameter int STEP_SHIFT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [POW_WIDTH-1:0]  pow_in,
   input  logic                  pow_valid,
   input  logic [POW_WIDTH-1:0]  ref_pow,
`ifdef AGC_HYST_EN
   input  logic [POW_WIDTH-1:0]  tol,
`endif
   input  logic                  enable,
   output logic [GAIN_WIDTH-1:0] gain_out,
   output logic                  gain_valid,
   output logic                  locked,
   output logic                  sat
);

   localparam int c_sum_w = POW_WIDTH + 2;
   localparam int c_cnt_w = $clog2(SETTLE_LEN + 1);
   localparam logic signed [c_sum_w-1:0] c_min = c_sum_w'(GAIN_MIN);
   localparam logic signed [c_sum_w-1:0] c_max = c_sum_w'(GAIN_MAX);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_UPDATE  = 2'd3
   } state_t;

   state_t                   r_state;
   logic [c_cnt_w-1:0]       r_cnt;
   logic signed [POW_WIDTH:0] r_err;

   logic signed [POW_WIDTH:0] w_shift;
   logic signed [POW_WIDTH:0] w_delta;
   logic signed [c_sum_w-1:0] w_sum;
   logic                      w_clip_lo;
   logic                      w_clip_hi;
   logic                      w_lock;
   logic [GAIN_WIDTH-1:0]     w_gain_next;
`ifdef AGC_HYST_EN
   logic signed [POW_WIDTH:0] w_abs;
`endif

   always_comb begin
      w_shift = r_err >>> STEP_SHIFT;
      w_delta = w_shift;
      // Small errors still move the gain by one code in the error's direction.
      if (w_shift == '0)
         w_delta = r_err[POW_WIDTH] ? '1 : {{POW_WIDTH{1'b0}}, 1'b1};
      w_sum = $signed({{(c_sum_w-GAIN_WIDTH){1'b0}}, gain_out})
            + $signed({w_delta[POW_WIDTH], w_delta});
      w_clip_lo = (w_sum < c_min);
      w_clip_hi = (w_sum > c_max);
      if (w_clip_lo)
         w_gain_next = GAIN_WIDTH'(GAIN_MIN);
      else if (w_clip_hi)
         w_gain_next = GAIN_WIDTH'(GAIN_MAX);
      else
         w_gain_next = GAIN_WIDTH'(w_sum);
`ifdef AGC_HYST_EN
      w_abs  = r_err[POW_WIDTH] ? -r_err : r_err;
      w_lock = ($unsigned(w_abs) <= {1'b0, tol});
`else
      w_lock = (r_err == '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_err      <= '0;
         gain_out   <= GAIN_WIDTH'(GAIN_INIT);
         gain_valid <= 1'b0;
         locked     <= 1'b0;
         sat        <= 1'b0;
      end else begin
         gain_valid <= 1'b0;
         if (!enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_SETTLE;
                  r_cnt   <= '0;
               end
               ST_SETTLE: begin
                  if (pow_valid) begin
                     if (r_cnt == c_cnt_last) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               ST_MEASURE: begin
                  if (pow_valid) begin
                     r_err   <= $signed({1'b0, ref_pow}) - $signed({1'b0, pow_in});
                     r_state <= ST_UPDATE;
                  end
               end
               ST_UPDATE: begin
                  if (w_lock) begin
                     locked  <= 1'b1;
                     sat     <= 1'b0;
                     r_state <= ST_MEASURE;
                  end else begin
                     locked <= 1'b0;
                     sat    <= w_clip_lo | w_clip_hi;
                     if (w_gain_next != gain_out) begin
                        gain_out   <= w_gain_next;
                        gain_valid <= 1'b1;
                        r_state    <= ST_SETTLE;
                        r_cnt      <= '0;
                     end else begin
                        r_state <= ST_MEASURE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_agc_gain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_agc_gain_ctrl                                               |
// | Brief   : Scoreboard bench for agc_gain_ctrl (directed vectors).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_agc_gain_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pow_in;
   logic        pow_valid;
   logic [15:0] ref_pow;
`ifdef AGC_HYST_EN
   logic [15:0] tol;
`endif
   logic        enable;
   logic [7:0]  gain_out;
   logic        gain_valid;
   logic        locked;
   logic        sat;

   agc_gain_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pow_in     (pow_in),
      .pow_valid  (pow_valid),
      .ref_pow    (ref_pow),
`ifdef AGC_HYST_EN
      .tol        (tol),
`endif
      .enable     (enable),
      .gain_out   (gain_out),
      .gain_valid (gain_valid),
      .locked     (locked),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] gain;
   } pulse_t;

   typedef struct {
      int         cyc;
      logic [7:0] gain;
      logic       locked;
      logic       sat;
      string      name;
   } snap_t;

   pulse_t pulse_q[$];
   snap_t  snap_q[$];
   int     checks   = 0;
   int     failures = 0;
   bit     done     = 1'b0;
   int     last_k   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted sample; a non-negative exp_g is the gain expected two edges later.
   task automatic sample(input logic [15:0] p, input logic [15:0] r, input int exp_g);
      pulse_t e;
      tick();
      pow_valid = 1'b1;
      pow_in    = p;
      ref_pow   = r;
      last_k    = cyc;
      if (exp_g >= 0) begin
         e.cyc  = cyc + 2;
         e.gain = 8'(exp_g);
         pulse_q.push_back(e);
      end
      tick();
      pow_valid = 1'b0;
   endtask

   task automatic discard(input int n, input logic [15:0] p, input logic [15:0] r);
      repeat (n) sample(p, r, -1);
   endtask

   task automatic expect_at(input int c, input int g, input logic l, input logic s,
                            input string name);
      snap_t e;
      e.cyc    = c;
      e.gain   = 8'(g);
      e.locked = l;
      e.sat    = s;
      e.name   = name;
      snap_q.push_back(e);
   endtask

   pulse_t m_pulse;
   snap_t  m_snap;

   always @(negedge clk) begin
      if (gain_valid) begin
         checks = checks + 1;
         if (pulse_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL pulse_unexpected cyc=%0d gain_out=%0d required no gain_valid",
                     cyc, gain_out);
         end else begin
            m_pulse = pulse_q.pop_front();
            if (m_pulse.cyc != cyc || m_pulse.gain != gain_out) begin
               failures = failures + 1;
               $display("FAIL pulse cyc=%0d gain_out=%0d required cyc=%0d gain_out=%0d",
                        cyc, gain_out, m_pulse.cyc, m_pulse.gain);
            end
         end
      end else if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
         m_pulse  = pulse_q.pop_front();
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL pulse_missing cyc=%0d gain_out=%0d required gain_valid at cyc=%0d gain_out=%0d",
                  cyc, gain_out, m_pulse.cyc, m_pulse.gain);
      end

      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         m_snap = snap_q.pop_front();
         checks = checks + 1;
         if (m_snap.cyc != cyc || gain_out != m_snap.gain || locked != m_snap.locked ||
             sat != m_snap.sat) begin
            failures = failures + 1;
            $display("FAIL %s cyc=%0d gain=%0d locked=%0b sat=%0b required cyc=%0d gain=%0d locked=%0b sat=%0b",
                     m_snap.name, cyc, gain_out, locked, sat,
                     m_snap.cyc, m_snap.gain, m_snap.locked, m_snap.sat);
         end
      end

      if (done || cyc > 20000) begin
         checks = checks + 1;
         if (cyc > 20000 || pulse_q.size() != 0 || snap_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain cyc=%0d pending_pulses=%0d pending_snaps=%0d required 0/0",
                     cyc, pulse_q.size(), snap_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      pow_valid = 1'b0;
      pow_in    = '0;
      ref_pow   = '0;
`ifdef AGC_HYST_EN
      tol       = '0;
`endif
      repeat (3) tick();
      expect_at(cyc, 128, 1'b0, 1'b0, "reset");
      rst = 1'b0;
      discard(4, 16'd1000, 16'd2000);
      expect_at(cyc, 128, 1'b0, 1'b0, "disabled_hold");

      // First decision after a full settle: err=1000 -> +62.
      enable = 1'b1;
      tick();
      discard(16, 16'd1000, 16'd2000);
      sample(16'd1000, 16'd2000, 190);
      expect_at(last_k + 2, 190, 1'b0, 1'b0, "step_190");

      // Drive to the upper bound, then a clipped no-change decision stays in MEASURE.
      discard(16, 16'd0, 16'd65535);
      sample(16'd0, 16'd65535, 255);
      expect_at(last_k + 2, 255, 1'b0, 1'b1, "clip_max");
      discard(16, 16'd0, 16'd65535);
      sample(16'd0, 16'd65535, -1);
      expect_at(last_k + 2, 255, 1'b0, 1'b1, "at_max_no_pulse");
      sample(16'd65535, 16'd0, 1);
      expect_at(last_k + 2, 1, 1'b0, 1'b1, "clip_min");

      // Exact match locks without moving the gain.
      discard(16, 16'd5000, 16'd5000);
      sample(16'd5000, 16'd5000, -1);
      expect_at(last_k + 2, 1, 1'b1, 1'b0, "lock_exact");
`ifdef AGC_HYST_EN
      tol = 16'd100;
      sample(16'd4950, 16'd5000, -1);
      expect_at(last_k + 2, 1, 1'b1, 1'b0, "hyst_lock");
      tick();
      tol = 16'd0;
`endif
      sample(16'd4995, 16'd5000, 2);
      expect_at(last_k + 2, 2, 1'b0, 1'b0, "err_p5");
      discard(16, 16'd5005, 16'd5000);
      sample(16'd5005, 16'd5000, 1);
      expect_at(last_k + 2, 1, 1'b0, 1'b0, "err_m5");
      discard(16, 16'd5005, 16'd5000);
      sample(16'd5005, 16'd5000, -1);
      expect_at(last_k + 2, 1, 1'b0, 1'b1, "at_min_no_pulse");
      sample(16'd4995, 16'd5000, 2);
      expect_at(last_k + 2, 2, 1'b0, 1'b0, "leave_min");

      // Disable mid-settle; the count must restart from zero.
      discard(10, 16'd1000, 16'd2000);
      enable = 1'b0;
      discard(2, 16'd1000, 16'd2000);
      expect_at(cyc, 2, 1'b0, 1'b0, "disable_hold");
      enable = 1'b1;
      tick();
      discard(16, 16'd1000, 16'd2000);
      sample(16'd1000, 16'd2000, 64);
      expect_at(last_k + 2, 64, 1'b0, 1'b0, "reenable_step");

      // Reset lands on the edge where UPDATE would have committed.
      discard(16, 16'd1000, 16'd2000);
      tick();
      pow_valid = 1'b1;
      pow_in    = 16'd1000;
      ref_pow   = 16'd2000;
      tick();
      pow_valid = 1'b0;
      rst       = 1'b1;
      tick();
      expect_at(cyc, 128, 1'b0, 1'b0, "rst_in_update");
      rst = 1'b0;
      discard(16, 16'd4995, 16'd5000);
      sample(16'd4995, 16'd5000, 129);
      expect_at(last_k + 2, 129, 1'b0, 1'b0, "step_129");

      repeat (4) tick();
      done = 1'b1;
   end

endmodule
`default_nettype wire
